// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its storage.
package sync_fifo_pkg;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_WIDTH = 8;

  // Binary pointer width needed to address `depth` entries.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return unsigned'($clog2(depth));
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read address.
// Contents are intentionally left unreset.
module sfifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned  DEPTH = DEF_DEPTH,
  parameter int unsigned  WIDTH = DEF_WIDTH,
  localparam int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller: pointers, occupancy, status and sticky error
// flags, with either registered-read or first-word-fall-through output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned  DEPTH     = DEF_DEPTH,
  parameter int unsigned  WIDTH     = DEF_WIDTH,
  parameter int unsigned  AF_THRESH = DEPTH - 2,
  parameter int unsigned  AE_THRESH = 1,
  parameter bit           FWFT      = 1'b0,
  localparam int unsigned AW        = ptr_w(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_udf;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_rd_data;

  assign w_wr_ok = w_en && !r_full;
  assign w_rd_ok = r_en && !r_empty;

  sfifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr),
    .i_wdata (data_in),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // Occupancy only moves when exactly one side is accepted.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Status flags are registered from the next count so they track r_count exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= CW'(AF_THRESH));
      r_aempty <= (w_count_nxt <= CW'(AE_THRESH));
      if (w_en && r_full)       r_ovf <= 1'b1;
      else if (err_clr)         r_ovf <= 1'b0;
      if (r_en && r_empty)      r_udf <= 1'b1;
      else if (err_clr)         r_udf <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue is shown directly; zero while empty.
      assign data_out   = r_empty ? '0 : w_rd_data;
      assign data_valid = !r_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_dv;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_dout <= '0;
          r_dv   <= 1'b0;
        end else begin
          r_dv <= w_rd_ok;
          if (w_rd_ok) r_dout <= w_rd_data;
        end
      end

      assign data_out   = r_dout;
      assign data_valid = r_dv;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one registered-read and one FWFT instance
// driven by the same stimulus.
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic       err_clr;

  logic [7:0] s_dout, f_dout;
  logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_cnt, f_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] d;

  sync_fifo #(.DEPTH(8), .WIDTH(8), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .err_clr(err_clr), .data_out(s_dout), .data_valid(s_dv), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo #(.DEPTH(8), .WIDTH(8), .FWFT(1'b1)) u_fw (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .err_clr(err_clr), .data_out(f_dout), .data_valid(f_dv), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " count"}, 32'(s_cnt), 32'd0);
    chk({tag, " empty"}, 32'(s_empty), 32'd1);
    chk({tag, " full"}, 32'(s_full), 32'd0);
    chk({tag, " ae"}, 32'(s_ae), 32'd1);
    chk({tag, " af"}, 32'(s_af), 32'd0);
    chk({tag, " dv"}, 32'(s_dv), 32'd0);
    chk({tag, " dout"}, 32'(s_dout), 32'd0);
    chk({tag, " ovf"}, 32'(s_ovf), 32'd0);
    chk({tag, " udf"}, 32'(s_udf), 32'd0);
    chk({tag, " fw dv"}, 32'(f_dv), 32'd0);
    chk({tag, " fw dout"}, 32'(f_dout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
    tick(); tick();
    chk_reset("reset");
    rst_n = 1'b1;

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      tick();
      chk($sformatf("fill%0d count", i), 32'(s_cnt), 32'(i));
      chk($sformatf("fill%0d af", i), 32'(s_af), 32'(i >= 6));
      chk($sformatf("fill%0d ae", i), 32'(s_ae), 32'(i <= 1));
      chk($sformatf("fill%0d full", i), 32'(s_full), 32'(i == 8));
    end

    // Overflow: 0xAA rejected, flag sticky until cleared.
    data_in = 8'hAA;
    tick();
    w_en = 1'b0;
    chk("ovf set", 32'(s_ovf), 32'd1);
    chk("ovf count", 32'(s_cnt), 32'd8);
    tick();
    chk("ovf sticky", 32'(s_ovf), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf clr", 32'(s_ovf), 32'd0);
    w_en = 1'b1; err_clr = 1'b1;
    tick();
    w_en = 1'b0; err_clr = 1'b0;
    chk("ovf set wins", 32'(s_ovf), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf clr2", 32'(s_ovf), 32'd0);

    // Drain with gaps: data_valid pulses once per read, data_out holds.
    for (int i = 1; i <= 8; i++) begin
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk($sformatf("rd%0d dv", i), 32'(s_dv), 32'd1);
      chk($sformatf("rd%0d dout", i), 32'(s_dout), 32'(i));
      chk($sformatf("rd%0d count", i), 32'(s_cnt), 32'(8 - i));
      tick();
      chk($sformatf("rd%0d dv low", i), 32'(s_dv), 32'd0);
      chk($sformatf("rd%0d hold", i), 32'(s_dout), 32'(i));
    end
    chk("drain empty", 32'(s_empty), 32'd1);
    chk("drain ae", 32'(s_ae), 32'd1);

    // Simultaneous read/write while empty: write only, underflow set.
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h33;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("udf set", 32'(s_udf), 32'd1);
    chk("udf count", 32'(s_cnt), 32'd1);
    chk("udf dv", 32'(s_dv), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("udf clr", 32'(s_udf), 32'd0);

    // Bring count to 4, then stream 20 simultaneous read/writes.
    q = {8'h33};
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; data_in = 8'(8'h34 + i);
      q.push_back(data_in);
      tick();
    end
    w_en = 1'b0;
    chk("pre-stream count", 32'(s_cnt), 32'd4);
    for (int k = 0; k < 20; k++) begin
      w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'h40 + k);
      tick();
      d = q.pop_front();
      q.push_back(data_in);
      chk($sformatf("stream%0d count", k), 32'(s_cnt), 32'd4);
      chk($sformatf("stream%0d dout", k), 32'(s_dout), 32'(d));
      chk($sformatf("stream%0d dv", k), 32'(s_dv), 32'd1);
    end
    w_en = 1'b0; r_en = 1'b0;

    // Count 5 then reset with requests pending; reset wins.
    w_en = 1'b1; data_in = 8'h99;
    tick();
    chk("pre-reset count", 32'(s_cnt), 32'd5);
    rst_n = 1'b0; r_en = 1'b1;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk_reset("midreset");
    rst_n = 1'b1;

    // Reset while full.
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = 8'(8'hC0 + i);
      tick();
    end
    chk("full before reset", 32'(s_full), 32'd1);
    rst_n = 1'b0; r_en = 1'b1;
    tick();
    chk_reset("fullreset");
    rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0;

    // FWFT: word written into empty FIFO shows up the next cycle.
    w_en = 1'b1; data_in = 8'h5C;
    tick();
    w_en = 1'b0;
    chk("fw dout", 32'(f_dout), 32'h5C);
    chk("fw dv", 32'(f_dv), 32'd1);
    chk("fw std dv", 32'(s_dv), 32'd0);
    w_en = 1'b1; data_in = 8'h6D;
    tick();
    w_en = 1'b0;
    chk("fw head held", 32'(f_dout), 32'h5C);
    r_en = 1'b1;
    tick();
    chk("fw next", 32'(f_dout), 32'h6D);
    chk("fw count", 32'(f_cnt), 32'd1);
    tick();
    r_en = 1'b0;
    chk("fw empty", 32'(f_empty), 32'd1);
    chk("fw dv low", 32'(f_dv), 32'd0);
    chk("fw udf clear", 32'(f_udf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, >= 4.
REQ-002 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full asserts at count >= AF_THRESH; legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 1: almost_empty asserts at count <= AE_THRESH; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL use one clock, with synchronous active-low reset: clk  input  1  sole clock, all logic on posedge; rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have w_en  input  1  write request.
REQ-008 SHALL have data_in  input  WIDTH  write data.
REQ-009 SHALL have r_en  input  1  read request (pop in FWFT mode).
REQ-010 SHALL have err_clr  input  1  clears sticky error flags.
REQ-011 SHALL have data_out  output  WIDTH  read data.
REQ-012 SHALL have data_valid  output  1  data_out holds a valid word.
REQ-013 SHALL have full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write SHALL be accepted iff w_en && !full; the word is stored at wptr and wptr increments modulo DEPTH.
REQ-017 Read SHALL be accepted iff r_en && !empty; rptr increments modulo DEPTH.
REQ-018 Pointers SHALL be $clog2(DEPTH)-bit binary and wrap naturally from DEPTH-1 to 0.
REQ-019 count SHALL update each cycle: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-020 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both derived from the registered count.
REQ-021 Simultaneous w_en and r_en while full: the read SHALL be accepted, the write rejected, and overflow set.
REQ-022 Simultaneous w_en and r_en while empty: the write SHALL be accepted, the read rejected, and underflow set.
REQ-023 w_en while full SHALL set overflow; r_en while empty SHALL set underflow. Both flags SHALL hold until err_clr=1 or reset; a set event in the same cycle as err_clr SHALL win.
REQ-024 With FWFT=0, data_out SHALL register mem[rptr] one cycle after an accepted read; data_valid SHALL pulse high for exactly that cycle; data_out SHALL hold its value otherwise.
REQ-025 With FWFT=1, data_out SHALL present mem[rptr] whenever !empty, and data_valid SHALL equal !empty.
REQ-026 With FWFT=1, a word written into an empty FIFO SHALL appear on data_out the cycle after the write.
REQ-027 Rejected operations SHALL NOT change memory, pointers or count.

Reset
REQ-028 On clk edge with rst_n=0: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0, data_out=0, overflow=0, underflow=0.
REQ-029 Reset SHALL take priority over all requests, including mid-operation reset while full; memory contents are not reset.

Structure
REQ-030 A shared package sync_fifo_pkg SHALL hold the default DEPTH/WIDTH constants and a function returning pointer width from DEPTH.
REQ-031 Storage SHALL be the single sub-module sfifo_ram: write port plus read address, no reset; the controller holds pointers, count and flags.

Verification
REQ-032 Reset, then 8 writes 0x01..0x08 with DEPTH=8 -> full=1 after the 8th, almost_full=1 from count 6, count=8.
REQ-033 Full FIFO, w_en=1 with data 0xAA -> overflow=1, count stays 8, 0xAA never read; err_clr pulse -> overflow=0.
REQ-034 FWFT=0, 8 reads after REQ-032 -> data_out 0x01..0x08, one cycle after each r_en, data_valid pulsing; empty=1 at the end.
REQ-035 Count=4, w_en and r_en together for 20 cycles -> count stays 4, pointers wrap, read order matches write order.
REQ-036 FWFT=1, empty FIFO, write 0x5C -> data_out=0x5C and data_valid=1 on the next cycle; r_en -> empty=1.
REQ-037 Empty FIFO, w_en and r_en together -> underflow=1, count=1; rst_n=0 at count=5 -> all REQ-028 values next cycle.
